// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Scoreboard hazard and forwarding unit for the in-order pipeline. It tracks
// at most one pending writer per architectural register. Variable-latency
// producers (loads, mul/div) are supported. The block:
//   - stalls decode on a RAW whose result is not yet forwardable, or on a WAW
//     against a register that still has a pending writer;
//   - selects a forwarding source for each EX operand;
//   - rolls back the reservation made by the instruction squashed in EX when
//     a taken branch flushes the pipe;
//   - counts stall cycles in a saturating counter.
//
// Ports
//   clk_i, rstn_i          clock, synchronous active-low reset
//   id_valid_i             decode holds a valid instruction
//   id_rs1_i/id_rs2_i      decode source indices
//   id_rs1_use_i/_rs2_     source is actually read
//   id_rd_i, id_rd_we_i    decode destination and write enable
//   id_lat_i               cycles until the result is forwardable (0=ALU)
//   id_stall_o             hold fetch/decode, insert a bubble into EX
//   flush_i                taken branch in EX, squash decode and EX
//   wb_valid_i, wb_rd_i    register file write this cycle
//   ex_rs1_i/ex_rs2_i      register file operand values latched into EX
//   ex_rs1_idx_i/_rs2_     EX operand indices
//   fwd_valid_i/rd_i/data_i  forwarding sources, index 0 youngest
//   rs1_o/rs2_o            EX operands after forwarding
//   rs1_sel_o/rs2_sel_o    0 = register file, k = source k-1
//   stall_cnt_o            saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int FWD_STAGES = 2,
  parameter int MAX_LAT    = 8,
  localparam int RW        = $clog2(NREG),
  localparam int CW        = $clog2(MAX_LAT + 1),
  localparam int SW        = $clog2(FWD_STAGES + 1)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       id_valid_i,
  input  logic [RW-1:0]              id_rs1_i,
  input  logic [RW-1:0]              id_rs2_i,
  input  logic                       id_rs1_use_i,
  input  logic                       id_rs2_use_i,
  input  logic [RW-1:0]              id_rd_i,
  input  logic                       id_rd_we_i,
  input  logic [CW-1:0]              id_lat_i,
  output logic                       id_stall_o,
  input  logic                       flush_i,
  input  logic                       wb_valid_i,
  input  logic [RW-1:0]              wb_rd_i,
  input  logic [XLEN-1:0]            ex_rs1_i,
  input  logic [XLEN-1:0]            ex_rs2_i,
  input  logic [RW-1:0]              ex_rs1_idx_i,
  input  logic [RW-1:0]              ex_rs2_idx_i,
  input  logic [FWD_STAGES-1:0]      fwd_valid_i,
  input  logic [FWD_STAGES*RW-1:0]   fwd_rd_i,
  input  logic [FWD_STAGES*XLEN-1:0] fwd_data_i,
  output logic [XLEN-1:0]            rs1_o,
  output logic [XLEN-1:0]            rs2_o,
  output logic [SW-1:0]              rs1_sel_o,
  output logic [SW-1:0]              rs2_sel_o,
  output logic [31:0]                stall_cnt_o
);

  typedef struct packed {
    logic [SW-1:0]   sel;
    logic [XLEN-1:0] data;
  } fwdPick_t;

  logic [NREG-1:0] busy;
  logic [CW-1:0]   cnt [NREG];
  logic            recValid;
  logic [RW-1:0]   recRd;
  logic [31:0]     stallCnt;

  logic            issue;
  logic            reserve;
  logic            rollback;
  logic            rs1Hazard;
  logic            rs2Hazard;
  logic            wawHazard;
  fwdPick_t        pick1;
  fwdPick_t        pick2;

  function automatic logic [31:0] satInc(input logic [31:0] v);
    satInc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Lowest-numbered matching source wins, so scan from the oldest source
  // down and let younger matches overwrite.
  function automatic fwdPick_t fwdSelect(input logic [RW-1:0]   idx,
                                         input logic [XLEN-1:0] rfVal);
    fwdPick_t res;
    res.sel  = '0;
    res.data = rfVal;
    if (idx == '0) begin
      res.data = '0;
    end else begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (fwd_valid_i[k] && (fwd_rd_i[k*RW +: RW] == idx)) begin
          res.sel  = SW'(k + 1);
          res.data = fwd_data_i[k*XLEN +: XLEN];
        end
      end
    end
    return res;
  endfunction

  // A RAW only stalls while the producer's result is not yet forwardable;
  // once cnt reaches zero a forwarding path carries it. x0 never stalls.
  always_comb begin
    rs1Hazard = id_rs1_use_i && (id_rs1_i != '0) && busy[id_rs1_i]
                && (cnt[id_rs1_i] != '0);
    rs2Hazard = id_rs2_use_i && (id_rs2_i != '0) && busy[id_rs2_i]
                && (cnt[id_rs2_i] != '0);
    wawHazard = id_rd_we_i && (id_rd_i != '0) && busy[id_rd_i];
    id_stall_o = id_valid_i && (rs1Hazard || rs2Hazard || wawHazard);
  end

  assign issue    = id_valid_i && !id_stall_o && !flush_i;
  assign reserve  = issue && id_rd_we_i && (id_rd_i != '0);
  assign rollback = flush_i && recValid;

  always_comb begin
    pick1     = fwdSelect(ex_rs1_idx_i, ex_rs1_i);
    pick2     = fwdSelect(ex_rs2_idx_i, ex_rs2_i);
    rs1_o     = pick1.data;
    rs1_sel_o = pick1.sel;
    rs2_o     = pick2.data;
    rs2_sel_o = pick2.sel;
  end

  assign stall_cnt_o = stallCnt;

  // Scoreboard state. The record of the last reservation lives for exactly
  // one cycle: that is the cycle its instruction sits in EX and can be
  // squashed by a flush. WAW stalls guarantee a single writer per register,
  // so clearing busy on rollback cannot lose an older pending write.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      busy     <= '0;
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      recValid <= 1'b0;
      recRd    <= '0;
      stallCnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (reserve && (id_rd_i == RW'(r))) begin
          busy[r] <= 1'b1;
          cnt[r]  <= id_lat_i;
        end else if (rollback && (recRd == RW'(r))) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (wb_valid_i && (wb_rd_i == RW'(r))) begin
          busy[r] <= 1'b0;
          cnt[r]  <= '0;
        end else if (busy[r] && (cnt[r] != '0)) begin
          cnt[r]  <= cnt[r] - CW'(1);
        end
      end
      busy[0]  <= 1'b0;
      cnt[0]   <= '0;
      recValid <= reserve;
      if (reserve) begin
        recRd <= id_rd_i;
      end
      if (id_stall_o) begin
        stallCnt <= satInc(stallCnt);
      end
    end
  end

  // Producer contract: an EX operand whose writer is forwardable (cnt==0)
  // but not yet written back must be offered by a forwarding source or by
  // the register file write happening this cycle.
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      assert (!((ex_rs1_idx_i != '0) && busy[ex_rs1_idx_i]
                && (cnt[ex_rs1_idx_i] == '0))
              || (pick1.sel != '0)
              || (wb_valid_i && (wb_rd_i == ex_rs1_idx_i)));
      assert (!((ex_rs2_idx_i != '0) && busy[ex_rs2_idx_i]
                && (cnt[ex_rs2_idx_i] == '0))
              || (pick2.sel != '0)
              || (wb_valid_i && (wb_rd_i == ex_rs2_idx_i)));
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int FS   = 2;
  localparam int ML   = 8;
  localparam int RW   = $clog2(NREG);
  localparam int CW   = $clog2(ML + 1);
  localparam int SW   = $clog2(FS + 1);

  logic               clk = 1'b0;
  logic               rstn;
  logic               idValid;
  logic [RW-1:0]      idRs1, idRs2, idRd;
  logic               idRs1Use, idRs2Use, idRdWe;
  logic [CW-1:0]      idLat;
  logic               idStall;
  logic               flush;
  logic               wbValid;
  logic [RW-1:0]      wbRd;
  logic [XLEN-1:0]    exRs1, exRs2;
  logic [RW-1:0]      exRs1Idx, exRs2Idx;
  logic [FS-1:0]      fwdValid;
  logic [FS*RW-1:0]   fwdRd;
  logic [FS*XLEN-1:0] fwdData;
  logic [XLEN-1:0]    rs1, rs2;
  logic [SW-1:0]      rs1Sel, rs2Sel;
  logic [31:0]        stallCnt;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.XLEN(XLEN), .NREG(NREG), .FWD_STAGES(FS), .MAX_LAT(ML)) dut (
    .clk_i(clk), .rstn_i(rstn), .id_valid_i(idValid),
    .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rs1_use_i(idRs1Use), .id_rs2_use_i(idRs2Use),
    .id_rd_i(idRd), .id_rd_we_i(idRdWe), .id_lat_i(idLat), .id_stall_o(idStall),
    .flush_i(flush), .wb_valid_i(wbValid), .wb_rd_i(wbRd),
    .ex_rs1_i(exRs1), .ex_rs2_i(exRs2), .ex_rs1_idx_i(exRs1Idx), .ex_rs2_idx_i(exRs2Idx),
    .fwd_valid_i(fwdValid), .fwd_rd_i(fwdRd), .fwd_data_i(fwdData),
    .rs1_o(rs1), .rs2_o(rs2), .rs1_sel_o(rs1Sel), .rs2_sel_o(rs2Sel),
    .stall_cnt_o(stallCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idIdle();
    idValid = 0; idRs1 = 0; idRs2 = 0; idRs1Use = 0; idRs2Use = 0;
    idRd = 0; idRdWe = 0; idLat = 0;
  endtask

  task automatic exIdle();
    exRs1 = 0; exRs2 = 0; exRs1Idx = 0; exRs2Idx = 0;
    fwdValid = 0; fwdRd = 0; fwdData = 0; wbValid = 0; wbRd = 0;
  endtask

  task automatic idWrite(input logic [RW-1:0] rd, input logic [CW-1:0] lat);
    idIdle();
    idValid = 1; idRd = rd; idRdWe = 1; idLat = lat;
  endtask

  initial begin
    rstn = 0; flush = 0;
    idIdle(); exIdle();

    // Reset with a valid decode reading x5
    idValid = 1; idRs1 = 5; idRs1Use = 1;
    tick(); tick();
    chk("rst_stall", {31'd0, idStall}, 32'd0);
    chk("rst_cnt", stallCnt, 32'd0);
    chk("rst_sel", {30'd0, rs1Sel}, 32'd0);
    rstn = 1; idIdle();
    tick();

    // ALU back-to-back on x3
    idWrite(3, 0); #1;
    chk("alu_prod_stall", {31'd0, idStall}, 32'd0);
    tick();
    idIdle(); idValid = 1; idRs1 = 3; idRs1Use = 1; #1;
    chk("alu_use_stall", {31'd0, idStall}, 32'd0);
    tick();
    idIdle();
    exRs1Idx = 3; exRs1 = 32'h11; fwdValid = 2'b01; fwdRd = {5'd0, 5'd3}; fwdData = {32'd0, 32'h55};
    exRs2Idx = 6; exRs2 = 32'hABCD; #1;
    chk("alu_fwd_sel", {30'd0, rs1Sel}, 32'd1);
    chk("alu_fwd_data", rs1, 32'h55);
    chk("rf_sel", {30'd0, rs2Sel}, 32'd0);
    chk("rf_data", rs2, 32'hABCD);
    tick();
    exIdle(); wbValid = 1; wbRd = 3;
    tick();
    exIdle();

    // Load-use on x4
    idWrite(4, 1);
    tick();
    idIdle(); idValid = 1; idRs1 = 4; idRs1Use = 1; #1;
    chk("ld_stall1", {31'd0, idStall}, 32'd1);
    tick();
    chk("ld_stall2", {31'd0, idStall}, 32'd0);
    chk("ld_cnt", stallCnt, 32'd1);
    tick();
    idIdle();
    exRs1Idx = 4; exRs1 = 32'h0; fwdValid = 2'b01; fwdRd = {5'd0, 5'd4}; fwdData = {32'd0, 32'h1234_5678}; #1;
    chk("ld_fwd_sel", {30'd0, rs1Sel}, 32'd1);
    chk("ld_fwd_data", rs1, 32'h1234_5678);
    tick();
    exIdle(); wbValid = 1; wbRd = 4;
    tick();
    exIdle();

    // Divide, latency 6, to x7; consumer reads x7 via rs2
    idWrite(7, 6);
    tick();
    idIdle(); idValid = 1; idRs2 = 7; idRs2Use = 1; #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("div_stall%0d", i), {31'd0, idStall}, 32'd1);
      tick();
    end
    chk("div_release", {31'd0, idStall}, 32'd0);
    tick();
    // Consumer in EX takes x7 from source 1; decode now holds a WAW to x7
    idWrite(7, 0);
    exRs2Idx = 7; fwdValid = 2'b10; fwdRd = {5'd7, 5'd0}; fwdData = {32'hD1D1, 32'h0}; #1;
    chk("div_fwd_sel", {30'd0, rs2Sel}, 32'd2);
    chk("div_fwd_data", rs2, 32'hD1D1);
    chk("waw_stall1", {31'd0, idStall}, 32'd1);
    tick();
    exIdle(); wbValid = 1; wbRd = 7; #1;
    chk("waw_stall2", {31'd0, idStall}, 32'd1);
    tick();
    exIdle(); #1;
    chk("waw_release", {31'd0, idStall}, 32'd0);
    chk("stall_total", stallCnt, 32'd9);
    tick();
    idIdle(); wbValid = 1; wbRd = 7;
    tick();
    exIdle();

    // Flush rolls back the x9 reservation
    idWrite(9, 3);
    tick();
    idIdle(); flush = 1;
    tick();
    flush = 0; idValid = 1; idRs1 = 9; idRs1Use = 1; #1;
    chk("flush_nostall", {31'd0, idStall}, 32'd0);
    tick();
    idIdle();

    // x0 is never reserved
    idWrite(0, 5);
    tick();
    idIdle(); idValid = 1; idRs1 = 0; idRs1Use = 1; idRdWe = 1; idRd = 0; #1;
    chk("x0_nostall", {31'd0, idStall}, 32'd0);
    tick();
    idIdle();

    // Source priority and x0 operand
    exRs2Idx = 2; exRs2 = 32'h99; fwdValid = 2'b11; fwdRd = {5'd2, 5'd2};
    fwdData = {32'hBBBB_0002, 32'hAAAA_0001}; #1;
    chk("prio_sel", {30'd0, rs2Sel}, 32'd1);
    chk("prio_data", rs2, 32'hAAAA_0001);
    exRs2Idx = 0; exRs2 = 32'h77; fwdValid = 2'b01; fwdRd = {5'd0, 5'd0}; #1;
    chk("x0_sel", {30'd0, rs2Sel}, 32'd0);
    chk("x0_data", rs2, 32'd0);
    chk("stall_final", stallCnt, 32'd9);
    tick();
    exIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
